// File: rtl/mack_bus_if.sv
// CPU-side bus bundle for the Mac-style address decoder / DTACK generator.
// master: CPU and external devices; slave: the bus controller.
interface mack_bus_if #(
    parameter int IO_SEL_W = 1
) ();
    localparam int NUM_IO = 2 ** IO_SEL_W;

    logic              AS;
    logic              DTACK_IN;
    logic              IACK;
    logic [11:0]       ADDR;
    logic              ROMEN;
    logic              RAMEN;
    logic [NUM_IO-1:0] IOEN;
    logic              DTACK;
    logic              BERR;
    logic              BOOT;

    modport master (
        output AS,
        output DTACK_IN,
        output IACK,
        output ADDR,
        input  ROMEN,
        input  RAMEN,
        input  IOEN,
        input  DTACK,
        input  BERR,
        input  BOOT
    );

    modport slave (
        input  AS,
        input  DTACK_IN,
        input  IACK,
        input  ADDR,
        output ROMEN,
        output RAMEN,
        output IOEN,
        output DTACK,
        output BERR,
        output BOOT
    );
endinterface

// File: rtl/mack_bus_ctrl.sv
// Bus controller: address decode, boot ROM overlay, wait states,
// DTACK generation and bus-error timeout for a 68000-style CPU.
module mack_bus_ctrl #(
    parameter int          BOOT_CYCLES  = 8,
    parameter logic [11:0] ROM_BASE     = 12'h380,
    parameter logic [11:0] ROM_MASK     = 12'hFC0,
    parameter logic [11:0] IO_BASE      = 12'h3E0,
    parameter logic [11:0] IO_MASK      = 12'hFE0,
    parameter int          IO_SEL_W     = 1,
    parameter logic [11:0] RAM_TOP      = 12'h200,
    parameter int          ROM_WAIT     = 2,
    parameter int          RAM_WAIT     = 0,
    parameter int          IO_WAIT      = 3,
    parameter bit          IO_EXT_DTACK = 1'b0,
    parameter int          BERR_TIMEOUT = 64
) (
    input logic       CLK,
    input logic       RST,
    mack_bus_if.slave bus
);
    localparam int NUM_IO = 2 ** IO_SEL_W;
    localparam int BCW = (BOOT_CYCLES > 0) ? $clog2(BOOT_CYCLES + 1) : 1;
    localparam int TCW = $clog2(BERR_TIMEOUT + 1);
    localparam logic [BCW-1:0] BOOT_LAST = BCW'(BOOT_CYCLES);
    localparam logic [TCW-1:0] TO_LAST = TCW'(BERR_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        WAIT,
        ACK,
        ERR
    } state_t;

    typedef enum logic [2:0] {
        R_NONE,
        R_ROM,
        R_RAM,
        R_IO,
        R_IACK
    } region_t;

    // Synchronisers and arming
    logic       as_m, as_s;
    logic       dti_m, dti_s;
    logic [1:0] sync_ok;
    logic       armed;

    // sync_ok keeps a pre-reset strobe from looking like a fresh idle bus
    always_ff @(posedge CLK) begin
        if (RST) begin
            as_m    <= 1'b1;
            as_s    <= 1'b1;
            dti_m   <= 1'b1;
            dti_s   <= 1'b1;
            sync_ok <= 2'b00;
            armed   <= 1'b0;
        end else begin
            as_m    <= bus.AS;
            as_s    <= as_m;
            dti_m   <= bus.DTACK_IN;
            dti_s   <= dti_m;
            sync_ok <= {sync_ok[0], 1'b1};
            armed   <= armed | (sync_ok[1] & as_s);
        end
    end

    // State and registered outputs
    state_t            state_q, state_d;
    region_t           region_q, region_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic [TCW-1:0]    tcnt_q, tcnt_d;
    logic              romen_q, romen_d;
    logic              ramen_q, ramen_d;
    logic [NUM_IO-1:0] ioen_q, ioen_d;
    logic              dtack_q, dtack_d;
    logic              berr_q, berr_d;
    logic [BCW-1:0]    bcnt_q;
    logic              boot_q;
    logic              bump;

    // Address decode, evaluated on the IDLE->DECODE edge
    logic                overlay;
    logic                io_hit, rom_hit, ram_hit;
    logic [IO_SEL_W-1:0] dec_slot;
    region_t             dec_region;

    assign overlay  = !(boot_q || (bcnt_q == BOOT_LAST));
    assign io_hit   = (bus.ADDR & IO_MASK) == (IO_BASE & IO_MASK);
    assign rom_hit  = (bus.ADDR & ROM_MASK) == (ROM_BASE & ROM_MASK);
    assign ram_hit  = bus.ADDR < RAM_TOP;
    assign dec_slot = bus.ADDR[4 -: IO_SEL_W];

    always_comb begin
        dec_region = R_NONE;
        if (!bus.IACK)
            dec_region = R_IACK;
        else if (overlay)
            dec_region = R_ROM;
        else if (io_hit)
            dec_region = R_IO;
        else if (rom_hit)
            dec_region = R_ROM;
        else if (ram_hit)
            dec_region = R_RAM;
    end

    // Termination sources for the latched region
    logic [3:0] rwait;
    logic       cnt_term, ext_term, cnt_done, term;

    always_comb begin
        rwait = 4'd0;
        unique case (region_q)
            R_ROM:   rwait = 4'(ROM_WAIT);
            R_RAM:   rwait = 4'(RAM_WAIT);
            R_IO:    rwait = 4'(IO_WAIT);
            default: rwait = 4'd0;
        endcase
    end

    assign cnt_term = (region_q == R_ROM) || (region_q == R_RAM) ||
                      ((region_q == R_IO) && !IO_EXT_DTACK);
    assign ext_term = (region_q == R_IACK) ||
                      ((region_q == R_IO) && IO_EXT_DTACK);
    assign cnt_done = (state_q == DECODE) ? (rwait == 4'd0)
                                          : (wcnt_q == 4'd0);
    assign term     = (ext_term && !dti_s) || (cnt_term && cnt_done);

    always_comb begin
        state_d  = state_q;
        region_d = region_q;
        wcnt_d   = wcnt_q;
        tcnt_d   = tcnt_q;
        romen_d  = romen_q;
        ramen_d  = ramen_q;
        ioen_d   = ioen_q;
        dtack_d  = dtack_q;
        berr_d   = berr_q;
        bump     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (armed && !as_s) begin
                    state_d  = DECODE;
                    region_d = dec_region;
                    tcnt_d   = '0;
                    romen_d  = dec_region != R_ROM;
                    ramen_d  = dec_region != R_RAM;
                    ioen_d   = (dec_region == R_IO)
                             ? ~(NUM_IO'(1) << dec_slot) : '1;
                end
            end
            DECODE, WAIT: begin
                if (as_s) begin
                    // CPU gave up on the cycle; it still counts for boot
                    state_d = IDLE;
                    romen_d = 1'b1;
                    ramen_d = 1'b1;
                    ioen_d  = '1;
                    bump    = 1'b1;
                end else if (term) begin
                    state_d = ACK;
                    dtack_d = 1'b0;
                end else if (tcnt_q == TO_LAST) begin
                    state_d = ERR;
                    berr_d  = 1'b0;
                    romen_d = 1'b1;
                    ramen_d = 1'b1;
                    ioen_d  = '1;
                end else begin
                    state_d = WAIT;
                    tcnt_d  = tcnt_q + 1'b1;
                    if (state_q == DECODE)
                        wcnt_d = rwait - 4'd1;
                    else if (wcnt_q != 4'd0)
                        wcnt_d = wcnt_q - 4'd1;
                end
            end
            ACK, ERR: begin
                if (as_s) begin
                    state_d = IDLE;
                    romen_d = 1'b1;
                    ramen_d = 1'b1;
                    ioen_d  = '1;
                    dtack_d = 1'b1;
                    berr_d  = 1'b1;
                    bump    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            region_q <= R_NONE;
            wcnt_q   <= '0;
            tcnt_q   <= '0;
            romen_q  <= 1'b1;
            ramen_q  <= 1'b1;
            ioen_q   <= '1;
            dtack_q  <= 1'b1;
            berr_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            region_q <= region_d;
            wcnt_q   <= wcnt_d;
            tcnt_q   <= tcnt_d;
            romen_q  <= romen_d;
            ramen_q  <= ramen_d;
            ioen_q   <= ioen_d;
            dtack_q  <= dtack_d;
            berr_q   <= berr_d;
        end
    end

    // Boot overlay counter saturates at BOOT_CYCLES
    always_ff @(posedge CLK) begin
        if (RST) begin
            bcnt_q <= '0;
            boot_q <= 1'(BOOT_CYCLES == 0);
        end else begin
            if (bump && (bcnt_q != BOOT_LAST))
                bcnt_q <= bcnt_q + 1'b1;
            boot_q <= boot_q | (bcnt_q == BOOT_LAST);
        end
    end

    assign bus.ROMEN = romen_q;
    assign bus.RAMEN = ramen_q;
    assign bus.IOEN  = ioen_q;
    assign bus.DTACK = dtack_q;
    assign bus.BERR  = berr_q;
    assign bus.BOOT  = boot_q;
endmodule
